tone_sweep_ctrl: RTL and testbench

TONE_SWEEP_CTRL -- requirements
Module: tone_sweep_ctrl

---
 rtl/tone_sweep_ctrl.sv | 164 ++++++++++++++++
 tb/tb_tone_sweep_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sweep_ctrl.sv
// Step-word sweep controller for an NCO: issues start..stop in step_incr
// increments over an AXI-Stream-style handshake, holding each step for a
// programmable dwell, with optional looping, abort and config checking.
module tone_sweep_ctrl #(
  parameter int ACC_WIDTH   = 32,
  parameter int DWELL_WIDTH = 24,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   aclk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   loop_en,
  input  logic [ACC_WIDTH-1:0]   start_step,
  input  logic [ACC_WIDTH-1:0]   stop_step,
  input  logic [ACC_WIDTH-1:0]   step_incr,
  input  logic [DWELL_WIDTH-1:0] dwell_cycles,
  output logic [ACC_WIDTH-1:0]   m_axis_step_tdata,
  output logic                   m_axis_step_tvalid,
  input  logic                   m_axis_step_tready,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  output logic [CNT_WIDTH-1:0]   step_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   cur_step_q, cur_step_d;
  logic [ACC_WIDTH-1:0]   first_q, first_d;
  logic [ACC_WIDTH-1:0]   last_q, last_d;
  logic [ACC_WIDTH-1:0]   incr_q, incr_d;
  logic [DWELL_WIDTH-1:0] dwell_len_q, dwell_len_d;
  logic                   loop_q, loop_d;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   cfg_err_q, cfg_err_d;

  // One extra bit so a wrap past all-ones is seen as a carry, not a small step.
  logic [ACC_WIDTH:0]     next_sum;
  logic                   handshake;
  logic [CNT_WIDTH-1:0]   count_inc;
  logic [DWELL_WIDTH-1:0] dwell_load;
  logic                   cfg_ok;

  assign next_sum   = {1'b0, cur_step_q} + {1'b0, incr_q};
  assign handshake  = (state_q == ISSUE) && m_axis_step_tready;
  assign count_inc  = (count_q == '1) ? count_q : count_q + CNT_ONE;
  // A zero dwell is treated as one so every step is held at least a cycle.
  assign dwell_load = (dwell_len_q == '0) ? DWELL_ONE : dwell_len_q;
  assign cfg_ok     = (step_incr != '0) && (start_step <= stop_step);

  // Next-state logic: abort wins over everything except reset.
  always_comb begin
    state_d     = state_q;
    cur_step_d  = cur_step_q;
    first_d     = first_q;
    last_d      = last_q;
    incr_d      = incr_q;
    dwell_len_d = dwell_len_q;
    loop_d      = loop_q;
    dwell_cnt_d = dwell_cnt_q;
    count_d     = count_q;
    cfg_err_d   = 1'b0;

    if (abort) begin
      state_d = IDLE;
      // A handshake in the abort cycle was seen by the NCO, so count it.
      if (handshake) count_d = count_inc;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              first_d     = start_step;
              last_d      = stop_step;
              incr_d      = step_incr;
              dwell_len_d = dwell_cycles;
              loop_d      = loop_en;
              cur_step_d  = start_step;
              count_d     = '0;
              state_d     = ISSUE;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        ISSUE: begin
          if (m_axis_step_tready) begin
            count_d     = count_inc;
            dwell_cnt_d = dwell_load;
            state_d     = DWELL;
          end
        end
        DWELL: begin
          if (dwell_cnt_q <= DWELL_ONE) begin
            dwell_cnt_d = '0;
            if (!next_sum[ACC_WIDTH] && (next_sum[ACC_WIDTH-1:0] <= last_q)) begin
              cur_step_d = next_sum[ACC_WIDTH-1:0];
              state_d    = ISSUE;
            end else if (loop_q) begin
              cur_step_d = first_q;
              state_d    = ISSUE;
            end else begin
              state_d = DONE;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q - DWELL_ONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_step_q  <= '0;
      first_q     <= '0;
      last_q      <= '0;
      incr_q      <= '0;
      dwell_len_q <= '0;
      loop_q      <= 1'b0;
      dwell_cnt_q <= '0;
      count_q     <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_step_q  <= cur_step_d;
      first_q     <= first_d;
      last_q      <= last_d;
      incr_q      <= incr_d;
      dwell_len_q <= dwell_len_d;
      loop_q      <= loop_d;
      dwell_cnt_q <= dwell_cnt_d;
      count_q     <= count_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign m_axis_step_tdata  = cur_step_q;
  assign m_axis_step_tvalid = (state_q == ISSUE);
  assign busy               = (state_q != IDLE);
  assign done               = (state_q == DONE);
  assign cfg_err            = cfg_err_q;
  assign step_count         = count_q;

endmodule

// File: tb/tb_tone_sweep_ctrl.sv
// Directed bench for tone_sweep_ctrl: normal sweep, back-pressure, config
// rejection, carry termination, loop with abort, zero dwell, reset mid-sweep.
module tb_tone_sweep_ctrl;

  logic        aclk = 1'b0;
  logic        rst, start, abort, loop_en;
  logic [31:0] start_step, stop_step, step_incr;
  logic [23:0] dwell_cycles;
  logic [31:0] tdata;
  logic        tvalid, tready;
  logic        busy, done, cfg_err;
  logic [2:0]  step_count;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] hs_d [16];
  int          hs_t [16];
  int          hs_n, done_n, end_cyc;

  tone_sweep_ctrl #(.ACC_WIDTH(32), .DWELL_WIDTH(24), .CNT_WIDTH(3)) dut (
    .aclk               (aclk),
    .rst                (rst),
    .start              (start),
    .abort              (abort),
    .loop_en            (loop_en),
    .start_step         (start_step),
    .stop_step          (stop_step),
    .step_incr          (step_incr),
    .dwell_cycles       (dwell_cycles),
    .m_axis_step_tdata  (tdata),
    .m_axis_step_tvalid (tvalid),
    .m_axis_step_tready (tready),
    .busy               (busy),
    .done               (done),
    .cfg_err            (cfg_err),
    .step_count         (step_count)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic go(input logic [31:0] ss, input logic [31:0] sp, input logic [31:0] inc,
                    input logic [23:0] dw, input logic lp);
    start_step = ss; stop_step = sp; step_incr = inc; dwell_cycles = dw; loop_en = lp;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Observe until busy drops; cycle 0 is the first cycle after start.
  task automatic run(input int maxc, input int abort_at);
    hs_n = 0; done_n = 0; end_cyc = -1;
    for (int c = 0; c < maxc; c++) begin
      abort = (c == abort_at);
      if (tvalid && tready && hs_n < 16) begin
        hs_d[hs_n] = tdata;
        hs_t[hs_n] = c;
        hs_n++;
      end
      if (done) done_n++;
      if (!busy) begin
        end_cyc = c;
        break;
      end
      tick;
    end
    abort = 1'b0;
    if (end_cyc < 0) chk("run_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0; tready = 1'b0;
    start_step = '0; stop_step = '0; step_incr = '0; dwell_cycles = '0;
    tick; tick;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_count", step_count, 0);
    rst = 1'b0;
    tick;

    // Basic 4-step sweep; inputs scrambled after start must not matter.
    tready = 1'b1;
    go(32'h100, 32'h400, 32'h100, 24'd3, 1'b0);
    start_step = 32'h0; stop_step = 32'hFFFF_FFFF; step_incr = 32'h1; dwell_cycles = 24'd0;
    loop_en = 1'b1;
    run(40, -1);
    chk("sw_hs_n", hs_n, 4);
    chk("sw_d0", hs_d[0], 32'h100);
    chk("sw_d1", hs_d[1], 32'h200);
    chk("sw_d2", hs_d[2], 32'h300);
    chk("sw_d3", hs_d[3], 32'h400);
    chk("sw_gap01", hs_t[1] - hs_t[0], 4);
    chk("sw_gap23", hs_t[3] - hs_t[2], 4);
    chk("sw_done_n", done_n, 1);
    chk("sw_end", end_cyc, 17);
    chk("sw_count", step_count, 4);
    chk("sw_idle_hold", tdata, 32'h400);
    loop_en = 1'b0;

    // Back-pressure: hold 5 cycles; a start mid-stall is ignored.
    tready = 1'b0;
    go(32'h10, 32'h10, 32'h1, 24'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 0);
      start_step = 32'h99;
      chk("bp_tvalid", tvalid, 1);
      chk("bp_tdata", tdata, 32'h10);
      tick;
    end
    start = 1'b0;
    tready = 1'b1;
    chk("bp_tvalid_hs", tvalid, 1);
    chk("bp_count0", step_count, 0);
    tick;
    chk("bp_dw1_tvalid", tvalid, 0);
    chk("bp_dw1_busy", busy, 1);
    chk("bp_dw1_count", step_count, 1);
    chk("bp_dw1_tdata", tdata, 32'h10);
    tick;
    chk("bp_dw2_tvalid", tvalid, 0);
    chk("bp_dw2_done", done, 0);
    tick;
    chk("bp_done", done, 1);
    tick;
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_done", done, 0);

    // Rejected configurations.
    go(32'h100, 32'h400, 32'h0, 24'd1, 1'b0);
    chk("ce0_cfg_err", cfg_err, 1);
    chk("ce0_busy", busy, 0);
    chk("ce0_tvalid", tvalid, 0);
    tick;
    chk("ce0_pulse", cfg_err, 0);
    go(32'h500, 32'h400, 32'h100, 24'd1, 1'b0);
    chk("ce1_cfg_err", cfg_err, 1);
    chk("ce1_busy", busy, 0);
    tick;
    chk("ce1_pulse", cfg_err, 0);
    chk("ce1_busy2", busy, 0);

    // Carry out of the accumulator ends the sweep.
    go(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 24'd1, 1'b0);
    run(40, -1);
    chk("cy_hs_n", hs_n, 2);
    chk("cy_d0", hs_d[0], 32'hFFFF_FF00);
    chk("cy_d1", hs_d[1], 32'hFFFF_FF80);
    chk("cy_done_n", done_n, 1);

    // Loop A,B,A then abort in the third dwell.
    go(32'h20, 32'h30, 32'h10, 24'd2, 1'b1);
    run(40, 7);
    chk("lp_hs_n", hs_n, 3);
    chk("lp_d0", hs_d[0], 32'h20);
    chk("lp_d1", hs_d[1], 32'h30);
    chk("lp_d2", hs_d[2], 32'h20);
    chk("lp_end", end_cyc, 8);
    chk("lp_done_n", done_n, 0);
    chk("lp_tvalid", tvalid, 0);
    chk("lp_count", step_count, 3);
    chk("lp_tdata", tdata, 32'h20);

    // Counter saturates (3-bit here) over a long looped sweep.
    go(32'h5, 32'h5, 32'h1, 24'd1, 1'b1);
    run(60, 19);
    chk("sat_hs_n", hs_n, 10);
    chk("sat_count", step_count, 7);

    // Abort beats a simultaneous handshake but the handshake still counts.
    go(32'h40, 32'h80, 32'h40, 24'd5, 1'b0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_tvalid", tvalid, 0);
    chk("ab_count", step_count, 1);
    chk("ab_done", done, 0);
    // Abort beats start in IDLE.
    abort = 1'b1;
    go(32'h40, 32'h80, 32'h40, 24'd5, 1'b0);
    abort = 1'b0;
    chk("abs_busy", busy, 0);
    chk("abs_cfg_err", cfg_err, 0);
    chk("abs_count", step_count, 1);

    // Zero dwell behaves like one.
    go(32'h1, 32'h3, 32'h1, 24'd0, 1'b0);
    run(40, -1);
    chk("dz_hs_n", hs_n, 3);
    chk("dz_gap", hs_t[1] - hs_t[0], 2);
    chk("dz_d2", hs_d[2], 32'h3);
    chk("dz_done_n", done_n, 1);

    // Reset mid-ISSUE clears everything, beating a concurrent start.
    tready = 1'b0;
    go(32'h77, 32'h99, 32'h1, 24'd4, 1'b0);
    chk("mr_pre_tvalid", tvalid, 1);
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    tick;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    chk("mr_tvalid", tvalid, 0);
    chk("mr_tdata", tdata, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_cfg_err", cfg_err, 0);
    chk("mr_count", step_count, 0);
    tick;
    chk("mr_busy2", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
